// File: rtl/datapath_xyz.sv
// -----------------------------------------------------------------------------
// datapath_xyz
// Calculator datapath that executes the register-control codes produced by the
// calculator control unit. Holds an operand register X, an accumulator Y and a
// display register Z, an adder/subtractor (ULA) feeding Y, and status flags.
// One control word is applied per clock edge while en is high.
//
// Optional feature macro: DATAPATH_SHIFT_LEFT_EN
//    defined   -> auxY=011 shifts Y left by one with zero fill
//    undefined -> auxY=011 is an illegal code (Y holds, err is set)
//
// Ports:
//    clk     in   rising-edge clock
//    rst_n   in   asynchronous active-low reset
//    en      in   apply the control word at this edge; otherwise hold all state
//    auxX    in   X code: 00 clear, 01 load din, 10 hold, 11 illegal
//    auxY    in   Y code: 000 clear, 001 load ULA, 010 hold, 011 shift left,
//                 100 shift right, 101..111 illegal
//    auxZ    in   Z code: 00 clear, 01 load Y, 10 hold, 11 illegal
//    auxULA  in   0 selects Y+X, 1 selects Y-X
//    din     in   input operand
//    X,Y,Z   out  register contents
//    ovf     out  signed overflow of the last ULA result loaded into Y
//    zero    out  registered Z==0
//    err     out  sticky illegal-code flag
// -----------------------------------------------------------------------------
module datapath_xyz #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       auxX,
   input  logic [2:0]       auxY,
   input  logic [1:0]       auxZ,
   input  logic             auxULA,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] X,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Z,
   output logic             ovf,
   output logic             zero,
   output logic             err
);

   logic [WIDTH-1:0] r_x;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] r_z;
   logic             r_ovf;
   logic             r_zero;
   logic             r_err;

   logic [WIDTH-1:0] w_ulaRes;
   logic             w_ulaOvf;
   logic [WIDTH-1:0] w_xNext;
   logic [WIDTH-1:0] w_yNext;
   logic [WIDTH-1:0] w_zNext;
   logic             w_ovfNext;
   logic             w_illX;
   logic             w_illY;
   logic             w_illZ;
   logic             w_fullClear;

   // The ULA always works on the pre-edge register values, so a Y load sees the
   // old X even if X is being reloaded at the same edge. Overflow compares the
   // result sign against Y: for add the operands must agree in sign, for
   // subtract they must disagree, before a sign flip counts as overflow.
   always_comb begin
      w_ulaRes = '0;
      w_ulaOvf = 1'b0;
      if (auxULA) begin
         w_ulaRes = r_y - r_x;
         w_ulaOvf = (r_y[WIDTH-1] != r_x[WIDTH-1]) &&
                    (w_ulaRes[WIDTH-1] != r_y[WIDTH-1]);
      end else begin
         w_ulaRes = r_y + r_x;
         w_ulaOvf = (r_y[WIDTH-1] == r_x[WIDTH-1]) &&
                    (w_ulaRes[WIDTH-1] != r_y[WIDTH-1]);
      end
   end

   // Next-state decode for each register. An illegal code on a field leaves
   // that register holding and raises its illegal flag; the other fields decode
   // independently. Z loads the old Y regardless of what Y does this edge.
   always_comb begin
      w_xNext   = r_x;
      w_yNext   = r_y;
      w_zNext   = r_z;
      w_ovfNext = r_ovf;
      w_illX    = 1'b0;
      w_illY    = 1'b0;
      w_illZ    = 1'b0;

      case (auxX)
         2'b00:   w_xNext = '0;
         2'b01:   w_xNext = din;
         2'b10:   w_xNext = r_x;
         default: w_illX  = 1'b1;
      endcase

      case (auxY)
         3'b000: begin
            w_yNext   = '0;
            w_ovfNext = 1'b0;
         end
         3'b001: begin
            w_yNext   = w_ulaRes;
            w_ovfNext = w_ulaOvf;
         end
         3'b010:  w_yNext = r_y;
`ifdef DATAPATH_SHIFT_LEFT_EN
         3'b011:  w_yNext = {r_y[WIDTH-2:0], 1'b0};
`else
         3'b011:  w_illY  = 1'b1;
`endif
         3'b100:  w_yNext = {1'b0, r_y[WIDTH-1:1]};
         default: w_illY  = 1'b1;
      endcase

      case (auxZ)
         2'b00:   w_zNext = '0;
         2'b01:   w_zNext = r_y;
         2'b10:   w_zNext = r_z;
         default: w_illZ  = 1'b1;
      endcase
   end

   assign w_fullClear = (auxX == 2'b00) && (auxY == 3'b000) && (auxZ == 2'b00);

   // Single state register. With en low nothing moves. zero is derived from the
   // value Z is about to take so it always matches the registered Z. err is
   // sticky and only a full clear (or reset) drops it; a full clear contains no
   // illegal field, so the clear branch can simply take precedence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x    <= '0;
         r_y    <= '0;
         r_z    <= '0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b1;
         r_err  <= 1'b0;
      end else if (en) begin
         r_x    <= w_xNext;
         r_y    <= w_yNext;
         r_z    <= w_zNext;
         r_ovf  <= w_ovfNext;
         r_zero <= (w_zNext == '0);
         if (w_fullClear) begin
            r_err <= 1'b0;
         end else if (w_illX || w_illY || w_illZ) begin
            r_err <= 1'b1;
         end
      end
   end

   assign X    = r_x;
   assign Y    = r_y;
   assign Z    = r_z;
   assign ovf  = r_ovf;
   assign zero = r_zero;
   assign err  = r_err;

endmodule

// File: tb/tb_datapath_xyz.sv
// -----------------------------------------------------------------------------
// tb_datapath_xyz
// Directed testbench for datapath_xyz. Each task walks one scenario and compares
// the full output state {X,Y,Z,ovf,zero,err} against hand-computed values.
// Honours DATAPATH_SHIFT_LEFT_EN for the shift-left expectation.
// -----------------------------------------------------------------------------
module tb_datapath_xyz;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] auxX;
   logic [2:0] auxY;
   logic [1:0] auxZ;
   logic       auxULA;
   logic [7:0] din;
   logic [7:0] X;
   logic [7:0] Y;
   logic [7:0] Z;
   logic       ovf;
   logic       zero;
   logic       err;

   int vecCount;
   int missCount;

   logic [26:0] exp;
   logic [26:0] act;

   datapath_xyz #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .auxX   (auxX),
      .auxY   (auxY),
      .auxZ   (auxZ),
      .auxULA (auxULA),
      .din    (din),
      .X      (X),
      .Y      (Y),
      .Z      (Z),
      .ovf    (ovf),
      .zero   (zero),
      .err    (err)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output state packed as {X,Y,Z,ovf,zero,err}
   function automatic logic [26:0] outState();
      return {X, Y, Z, ovf, zero, err};
   endfunction

   // Apply one control word across one rising edge, then settle 1 unit past it
   task automatic drive(input logic e, input logic [1:0] ax, input logic [2:0] ay,
                        input logic [1:0] az, input logic u, input logic [7:0] d);
      en     = e;
      auxX   = ax;
      auxY   = ay;
      auxZ   = az;
      auxULA = u;
      din    = d;
      @(posedge clk);
      #1;
   endtask

   // Reset values after power-up reset
   task automatic test_reset();
      exp = {8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL reset_state got=%h expected=%h", act, exp);
      end
   endtask

   // Calculator sequence: load 5, load 3 with Y=5, add, shift right, display
   task automatic test_calculator();
      logic [26:0] expTab [5];
      expTab[0] = {8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      expTab[1] = {8'h03, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0};
      expTab[2] = {8'h03, 8'h08, 8'h00, 1'b0, 1'b1, 1'b0};
      expTab[3] = {8'h03, 8'h04, 8'h00, 1'b0, 1'b1, 1'b0};
      expTab[4] = {8'h00, 8'h00, 8'h04, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         case (i)
            0:       drive(1'b1, 2'b01, 3'b000, 2'b00, 1'b0, 8'h05);
            1:       drive(1'b1, 2'b01, 3'b001, 2'b10, 1'b0, 8'h03);
            2:       drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b0, 8'h00);
            3:       drive(1'b1, 2'b10, 3'b100, 2'b10, 1'b0, 8'h00);
            default: drive(1'b1, 2'b00, 3'b000, 2'b01, 1'b0, 8'h00);
         endcase
         act = outState();
         vecCount++;
         if (act !== expTab[i]) begin
            missCount++;
            $display("[TB] FAIL calc_step%0d got=%h expected=%h", i, act, expTab[i]);
         end
      end
   endtask

   // Signed overflow on add and subtract, and ovf persistence across shifts
   task automatic test_overflow();
      drive(1'b1, 2'b01, 3'b000, 2'b10, 1'b0, 8'h7F);
      drive(1'b1, 2'b01, 3'b001, 2'b10, 1'b0, 8'h01);
      drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b0, 8'h00);
      exp = {8'h01, 8'h80, 8'h04, 1'b1, 1'b0, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL ovf_add_7F got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b10, 3'b000, 2'b10, 1'b0, 8'h00);
      drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b1, 8'h00);
      exp = {8'h01, 8'hFF, 8'h04, 1'b0, 1'b0, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL sub_0_minus_1 got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b01, 3'b000, 2'b10, 1'b0, 8'h80);
      drive(1'b1, 2'b01, 3'b001, 2'b10, 1'b0, 8'h01);
      drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b1, 8'h00);
      exp = {8'h01, 8'h7F, 8'h04, 1'b1, 1'b0, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL ovf_sub_80 got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b10, 3'b100, 2'b10, 1'b0, 8'h00);
      exp = {8'h01, 8'h3F, 8'h04, 1'b1, 1'b0, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL ovf_kept_on_shift got=%h expected=%h", act, exp);
      end
   endtask

   // Same-edge sources: Z takes old Y, Y takes old X
   task automatic test_simultaneous();
      drive(1'b1, 2'b01, 3'b000, 2'b10, 1'b0, 8'h12);
      drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b0, 8'h00);
      drive(1'b1, 2'b10, 3'b000, 2'b01, 1'b0, 8'h00);
      exp = {8'h12, 8'h00, 8'h12, 1'b0, 1'b0, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL z_takes_old_y got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b01, 3'b001, 2'b10, 1'b0, 8'h09);
      exp = {8'h09, 8'h12, 8'h12, 1'b0, 1'b0, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL y_takes_old_x got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b00, 3'b100, 2'b01, 1'b0, 8'h00);
      exp = {8'h00, 8'h09, 8'h12, 1'b0, 1'b0, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL z_load_with_shift got=%h expected=%h", act, exp);
      end
   endtask

   // Illegal codes, sticky err, full clear, and en=0 freezing everything
   task automatic test_illegal();
      drive(1'b1, 2'b01, 3'b000, 2'b10, 1'b0, 8'h09);
      drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b0, 8'h00);
      drive(1'b1, 2'b11, 3'b001, 2'b10, 1'b0, 8'h55);
      exp = {8'h09, 8'h12, 8'h12, 1'b0, 1'b0, 1'b1};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL illegal_x got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b10, 3'b010, 2'b10, 1'b0, 8'h00);
      drive(1'b1, 2'b10, 3'b010, 2'b10, 1'b0, 8'h00);
      exp = {8'h09, 8'h12, 8'h12, 1'b0, 1'b0, 1'b1};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL err_sticky got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b01, 3'b101, 2'b00, 1'b0, 8'hA5);
      exp = {8'hA5, 8'h12, 8'h00, 1'b0, 1'b1, 1'b1};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL illegal_y_others_run got=%h expected=%h", act, exp);
      end

      drive(1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 8'h00);
      exp = {8'hA5, 8'h12, 8'h00, 1'b0, 1'b1, 1'b1};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL en0_full_clear got=%h expected=%h", act, exp);
      end

      drive(1'b1, 2'b00, 3'b000, 2'b00, 1'b0, 8'h00);
      exp = {8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL full_clear got=%h expected=%h", act, exp);
      end

      drive(1'b0, 2'b11, 3'b111, 2'b11, 1'b0, 8'h33);
      exp = {8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL en0_illegal got=%h expected=%h", act, exp);
      end
   endtask

   // Asynchronous reset between edges, then a normal first word
   task automatic test_reset_mid();
      drive(1'b1, 2'b01, 3'b000, 2'b00, 1'b0, 8'h07);
      drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b0, 8'h00);
      drive(1'b1, 2'b01, 3'b000, 2'b01, 1'b0, 8'h09);
      drive(1'b1, 2'b01, 3'b001, 2'b10, 1'b0, 8'h05);
      drive(1'b1, 2'b10, 3'b010, 2'b11, 1'b0, 8'h00);
      exp = {8'h05, 8'h09, 8'h07, 1'b0, 1'b0, 1'b1};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL pre_reset_state got=%h expected=%h", act, exp);
      end

      #2;
      rst_n = 1'b0;
      #1;
      exp = {8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL async_reset got=%h expected=%h", act, exp);
      end
      #1;
      rst_n = 1'b1;

      drive(1'b1, 2'b01, 3'b000, 2'b00, 1'b0, 8'h02);
      exp = {8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL first_after_reset got=%h expected=%h", act, exp);
      end
   endtask

   // auxY=011 behaviour depends on the shift-left build option
   task automatic test_shift_left();
      drive(1'b1, 2'b01, 3'b000, 2'b10, 1'b0, 8'h81);
      drive(1'b1, 2'b10, 3'b001, 2'b10, 1'b0, 8'h00);
      drive(1'b1, 2'b10, 3'b011, 2'b10, 1'b0, 8'h00);
`ifdef DATAPATH_SHIFT_LEFT_EN
      exp = {8'h81, 8'h02, 8'h00, 1'b0, 1'b1, 1'b0};
`else
      exp = {8'h81, 8'h81, 8'h00, 1'b0, 1'b1, 1'b1};
`endif
      act = outState();
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL shift_left got=%h expected=%h", act, exp);
      end
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      rst_n     = 1'b0;
      en        = 1'b0;
      auxX      = 2'b10;
      auxY      = 3'b010;
      auxZ      = 2'b10;
      auxULA    = 1'b0;
      din       = 8'h00;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_calculator();
      test_overflow();
      test_simultaneous();
      test_illegal();
      test_reset_mid();
      test_shift_left();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
